reset_button_ctrl: RTL and testbench
====================================

Name: reset_button_ctrl

Overview:
- Sits directly upstream of the FPGA reset generator on the board top level and drives that generator's force_rst_n input.
- Synchronizes and debounces an external pushbutton.
- A short press issues a fixed-length system reset request; a long press raises a one-cycle long_press event and no reset.
- A one-cycle software/debug request, sw_rst_req, also issues a reset request.

Parameters:
- ACTIVE_LEVEL, 1'b0: pin level meaning "pressed".
- SYNC_STAGES, 2: synchronizer flops on btn_pin, at least 2.
- DEBOUNCE_CYCLES, 240000: consecutive stable samples needed to accept a new level (10 ms at 24 MHz), at least 1.
- RST_PULSE_CYCLES, 16: cycles force_rst_n is held low per request, at least 1.
- LONG_PRESS_CYCLES, 48000000: debounced hold length that counts as a long press (2 s at 24 MHz), greater than DEBOUNCE_CYCLES.

Ports:
- clk  input  1  free-running oscillator clock.
- rst_n  input  1  synchronous active-low reset. Must come from a power-on source that force_rst_n does not assert.
- btn_pin  input  1  raw asynchronous button pin.
- sw_rst_req  input  1  single-cycle reset request, synchronous to clk.
- force_rst_n  output  1  active-low reset request to the reset generator.
- btn_db  output  1  debounced button state, 1 = pressed.
- long_press  output  1  single-cycle pulse when a hold reaches LONG_PRESS_CYCLES.

Behaviour:
- Clock and reset:
  - Single clock clk; reset is synchronous, active-low on rst_n.
  - All flops reset on a clk edge while rst_n=0.
- Reset values:
  - force_rst_n=1, btn_db=0, long_press=0.
  - Synchronizer flops reset to the released level (~ACTIVE_LEVEL).
  - Debounce counter and hold counter reset to 0; FSM resets to IDLE.
- Synchronizer:
  - SYNC_STAGES flops; then "pressed" = (synced == ACTIVE_LEVEL).
- Debounce:
  - The counter increments each cycle the synced "pressed" value differs from btn_db.
  - The counter clears to 0 on any cycle where they match.
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing, btn_db toggles on that edge and the counter clears.
  - Net latency from a stable pin change to the btn_db change is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - A bounce shorter than DEBOUNCE_CYCLES produces no btn_db change.
- Counter widths: $clog2(max+1) of the respective parameter. The hold counter saturates and never wraps.
- FSM states: IDLE, HELD, PULSE, WAIT_REL.
  - IDLE:
    - btn_db rising → HELD, hold counter cleared.
    - sw_rst_req → PULSE.
    - If both occur in the same cycle, sw_rst_req wins → PULSE.
  - HELD:
    - The hold counter increments each cycle.
    - btn_db falls before the counter reaches LONG_PRESS_CYCLES-1 → PULSE (short press).
    - Counter reaches LONG_PRESS_CYCLES-1 with btn_db still 1 → long_press=1 for exactly that next cycle, then → WAIT_REL.
    - sw_rst_req in HELD → PULSE immediately, and the press is abandoned.
  - PULSE:
    - force_rst_n=0 for exactly RST_PULSE_CYCLES cycles.
    - force_rst_n falls the cycle after the transition decision (it is a registered output).
    - sw_rst_req during PULSE is ignored; the pulse is not extended.
    - On exit: btn_db=1 → WAIT_REL, otherwise → IDLE.
  - WAIT_REL:
    - btn_db falls → IDLE. No reset is generated by this release.
    - sw_rst_req → PULSE.
- Reset mid-operation: rst_n=0 during PULSE deasserts force_rst_n (back to 1) on the same edge. No carry-over state.
- Output timing: force_rst_n and long_press are registered and glitch-free. Their source is clk only.

Decomposition:
- No shared package.
- FSM state encodings are localparams in this module.
- The default cycle constants (derived from CLK_MHZ=24) belong in the board-level constants header used by the FPGA tops.
- One natural sub-module: button_debounce, containing the synchronizer and debounce counter.
  - Parameters: ACTIVE_LEVEL, SYNC_STAGES, DEBOUNCE_CYCLES.
  - Output: btn_db.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=8, RST_PULSE_CYCLES=4, LONG_PRESS_CYCLES=32, ACTIVE_LEVEL=0.
- Reset: rst_n=0 for 3 cycles with btn_pin=0 → force_rst_n=1, btn_db=0, long_press=0 throughout; after release, btn_db=1 at cycle 10.
- Bounce: btn_pin pulses low for 5 cycles, three times, with 3-cycle gaps → btn_db stays 0 and force_rst_n stays 1.
- Short press: btn_pin low for 20 cycles, then high → btn_db=1 at cycle 10 and falls 10 cycles after release; force_rst_n=0 for exactly 4 cycles starting the cycle after btn_db falls.
- Long press: btn_pin low for 60 cycles → long_press=1 for exactly one cycle, 32 cycles after btn_db rises; no force_rst_n pulse on release.
- Software request: sw_rst_req pulse in IDLE → force_rst_n low 4 cycles; a second sw_rst_req during that pulse → still exactly 4 cycles.
- Priority and mid-operation reset:
  - sw_rst_req while HELD → immediate 4-cycle pulse, then WAIT_REL; the subsequent release gives no pulse.
  - rst_n=0 during PULSE → force_rst_n=1 on the next edge.

Source files
------------

// File: rtl/reset_button_ctrl_debounce.sv
// Pushbutton synchronizer plus debounce filter; btn_db is the filtered
// "pressed" level and only changes after DEBOUNCE_CYCLES consecutive disagreeing samples.
module button_debounce #(
  parameter logic ACTIVE_LEVEL    = 1'b0,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pin,
  output logic btn_db
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   pressed;

  // Synchronizer idles at the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{~ACTIVE_LEVEL}};
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_pin};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign pressed = (sync_q[SYNC_STAGES-1] == ACTIVE_LEVEL);

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (pressed != db_q) begin
      if (cnt_q == CntLast) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/reset_button_ctrl.sv
// Reset pushbutton controller: short press or sw_rst_req gives a fixed-length
// force_rst_n pulse, a long hold gives a single long_press event instead.
module reset_button_ctrl #(
  parameter logic ACTIVE_LEVEL      = 1'b0,
  parameter int   SYNC_STAGES       = 2,
  parameter int   DEBOUNCE_CYCLES   = 240000,
  parameter int   RST_PULSE_CYCLES  = 16,
  parameter int   LONG_PRESS_CYCLES = 48000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pin,
  input  logic sw_rst_req,
  output logic force_rst_n,
  output logic btn_db,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    PULSE    = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  localparam int HoldW  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int PulseW = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [HoldW-1:0]  HoldTrip  = HoldW'(LONG_PRESS_CYCLES - 2);
  localparam logic [HoldW-1:0]  HoldMax   = HoldW'(LONG_PRESS_CYCLES - 1);
  localparam logic [PulseW-1:0] PulseLast = PulseW'(RST_PULSE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [PulseW-1:0] pulse_q, pulse_d;
  logic              force_q, force_d;
  logic              long_q, long_d;
  logic              db_prev_q;
  logic              db_rise;

  button_debounce #(
    .ACTIVE_LEVEL    (ACTIVE_LEVEL),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_pin (btn_pin),
    .btn_db  (btn_db)
  );

  assign db_rise = btn_db & ~db_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      pulse_q   <= '0;
      force_q   <= 1'b1;
      long_q    <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pulse_q   <= pulse_d;
      force_q   <= force_d;
      long_q    <= long_d;
      db_prev_q <= btn_db;
    end
  end

  // Outputs are computed one cycle ahead so force_rst_n and long_press leave flops directly.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pulse_d = pulse_q;
    force_d = 1'b1;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sw_rst_req) begin
          state_d = PULSE;
          pulse_d = '0;
          force_d = 1'b0;
        end else if (db_rise) begin
          state_d = HELD;
          hold_d  = '0;
        end
      end
      HELD: begin
        if (sw_rst_req || !btn_db) begin
          state_d = PULSE;
          pulse_d = '0;
          force_d = 1'b0;
        end else if (hold_q == HoldTrip) begin
          // The counter reaches its last value on the same edge long_press rises.
          state_d = WAIT_REL;
          hold_d  = HoldMax;
          long_d  = 1'b1;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      PULSE: begin
        if (pulse_q == PulseLast) begin
          state_d = btn_db ? WAIT_REL : IDLE;
        end else begin
          pulse_d = pulse_q + PulseW'(1);
          force_d = 1'b0;
        end
      end
      WAIT_REL: begin
        if (sw_rst_req) begin
          state_d = PULSE;
          pulse_d = '0;
          force_d = 1'b0;
        end else if (!btn_db) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign force_rst_n = force_q;
  assign long_press  = long_q;

endmodule

// File: tb/tb_reset_button_ctrl.sv
// Self-checking bench for reset_button_ctrl: directed timing scenarios plus a
// randomized bouncing-pin run checked against a sliding-window debounce model.
module tb_reset_button_ctrl;

  localparam int SYNC   = 2;
  localparam int DEB    = 8;
  localparam int RPULSE = 4;
  localparam int LONGP  = 32;
  localparam int TRMAX  = 1024;
  localparam int SEL_DB = 0;
  localparam int SEL_FR = 1;
  localparam int SEL_LP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_pin = 1'b1;
  logic sw_rst_req = 1'b0;
  logic force_rst_n, btn_db, long_press;

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic dbTr[TRMAX];
  logic frTr[TRMAX];
  logic lpTr[TRMAX];
  bit   pressHist[TRMAX];

  reset_button_ctrl #(
    .ACTIVE_LEVEL      (1'b0),
    .SYNC_STAGES       (SYNC),
    .DEBOUNCE_CYCLES   (DEB),
    .RST_PULSE_CYCLES  (RPULSE),
    .LONG_PRESS_CYCLES (LONGP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_pin     (btn_pin),
    .sw_rst_req  (sw_rst_req),
    .force_rst_n (force_rst_n),
    .btn_db      (btn_db),
    .long_press  (long_press)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    bit pressNow;
    pressNow = (btn_pin == 1'b0);
    @(posedge clk);
    #1;
    if (t < TRMAX - 1) begin
      t++;
      pressHist[t] = pressNow;
      dbTr[t] = btn_db;
      frTr[t] = force_rst_n;
      lpTr[t] = long_press;
    end
  endtask

  task automatic applyStimulus(input logic pin, input logic sw, input int n);
    btn_pin = pin;
    sw_rst_req = sw;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic doReset(input logic pin, input int n);
    btn_pin = pin;
    sw_rst_req = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_force_rst_n", {31'd0, force_rst_n}, 1);
      checkOutput("reset_btn_db", {31'd0, btn_db}, 0);
      checkOutput("reset_long_press", {31'd0, long_press}, 0);
    end
    rst_n = 1'b1;
    t = 0;
  endtask

  function automatic logic trv(int sel, int i);
    case (sel)
      SEL_DB:  return dbTr[i];
      SEL_FR:  return frTr[i];
      default: return lpTr[i];
    endcase
  endfunction

  function automatic int firstAt(int sel, logic v, int from);
    for (int i = (from < 1) ? 1 : from; i <= t; i++)
      if (trv(sel, i) === v) return i;
    return -1;
  endfunction

  function automatic int countAt(int sel, logic v);
    int c = 0;
    for (int i = 1; i <= t; i++)
      if (trv(sel, i) === v) c++;
    return c;
  endfunction

  // Debounce input as seen SYNC edges after the pin was sampled; released before any history.
  function automatic bit pAt(int e);
    return (e - SYNC >= 1) ? pressHist[e - SYNC] : 1'b0;
  endfunction

  initial begin
    int rise, fall, lowStart, lpAt, lastToggle, len;
    bit dbModel, toggle;
    logic level;

    $display("[TB] start");

    // Reset with the button already held down.
    doReset(1'b0, 3);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("reset_db_rise_cycle", firstAt(SEL_DB, 1'b1, 1), SYNC + DEB);

    // Three short bounces never get accepted.
    doReset(1'b1, 2);
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 5);
      applyStimulus(1'b1, 1'b0, 3);
    end
    applyStimulus(1'b1, 1'b0, 20);
    checkOutput("bounce_db_high_cycles", countAt(SEL_DB, 1'b1), 0);
    checkOutput("bounce_force_low_cycles", countAt(SEL_FR, 1'b0), 0);

    // Short press.
    doReset(1'b1, 2);
    applyStimulus(1'b0, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 30);
    rise = firstAt(SEL_DB, 1'b1, 1);
    fall = firstAt(SEL_DB, 1'b0, rise);
    lowStart = firstAt(SEL_FR, 1'b0, 1);
    checkOutput("short_db_rise", rise, SYNC + DEB);
    checkOutput("short_db_fall", fall, 20 + SYNC + DEB);
    checkOutput("short_pulse_start", lowStart, 20 + SYNC + DEB + 1);
    checkOutput("short_pulse_end", firstAt(SEL_FR, 1'b1, lowStart), 20 + SYNC + DEB + 1 + RPULSE);
    checkOutput("short_pulse_total", countAt(SEL_FR, 1'b0), RPULSE);
    checkOutput("short_no_long", countAt(SEL_LP, 1'b1), 0);

    // Long press.
    doReset(1'b1, 2);
    applyStimulus(1'b0, 1'b0, 60);
    applyStimulus(1'b1, 1'b0, 30);
    rise = firstAt(SEL_DB, 1'b1, 1);
    lpAt = firstAt(SEL_LP, 1'b1, 1);
    checkOutput("long_db_rise", rise, SYNC + DEB);
    checkOutput("long_event_cycle", lpAt, SYNC + DEB + LONGP);
    checkOutput("long_event_width", countAt(SEL_LP, 1'b1), 1);
    checkOutput("long_db_fall", firstAt(SEL_DB, 1'b0, rise), 60 + SYNC + DEB);
    checkOutput("long_no_pulse", countAt(SEL_FR, 1'b0), 0);

    // Software request, with a second request landing inside the pulse.
    doReset(1'b1, 2);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 14);
    lowStart = firstAt(SEL_FR, 1'b0, 1);
    checkOutput("sw_pulse_start", lowStart, 4);
    checkOutput("sw_pulse_end", firstAt(SEL_FR, 1'b1, lowStart), 4 + RPULSE);
    checkOutput("sw_pulse_total", countAt(SEL_FR, 1'b0), RPULSE);

    // Software request while the button is held abandons the press.
    doReset(1'b1, 2);
    applyStimulus(1'b0, 1'b0, 15);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 14);
    applyStimulus(1'b1, 1'b0, 30);
    checkOutput("held_sw_pulse_start", firstAt(SEL_FR, 1'b0, 1), 16);
    checkOutput("held_sw_pulse_total", countAt(SEL_FR, 1'b0), RPULSE);
    checkOutput("held_sw_no_long", countAt(SEL_LP, 1'b1), 0);
    checkOutput("held_sw_db_fall", firstAt(SEL_DB, 1'b0, SYNC + DEB), 30 + SYNC + DEB);

    // Software request in the same cycle the debounced rise is seen.
    doReset(1'b1, 2);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 9);
    applyStimulus(1'b1, 1'b0, 20);
    checkOutput("prio_pulse_start", firstAt(SEL_FR, 1'b0, 1), SYNC + DEB + 1);
    checkOutput("prio_pulse_total", countAt(SEL_FR, 1'b0), RPULSE);
    checkOutput("prio_no_long", countAt(SEL_LP, 1'b1), 0);

    // Reset asserted in the middle of a pulse.
    doReset(1'b1, 2);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("mid_pulse_low", {31'd0, force_rst_n}, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_pulse_reset_force", {31'd0, force_rst_n}, 1);
    rst_n = 1'b1;
    t = 0;
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("post_reset_no_pulse", countAt(SEL_FR, 1'b0), 0);

    // Randomly bouncing pin against the sliding-window debounce rule.
    doReset(1'b1, 2);
    dbModel = 1'b0;
    lastToggle = 0;
    while (t < 700) begin
      level = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      for (int c = 0; c < len; c++) begin
        applyStimulus(level, 1'b0, 1);
        toggle = (t - lastToggle >= DEB);
        for (int k = 0; k < DEB; k++)
          if (toggle && pAt(t - k) == dbModel) toggle = 1'b0;
        if (toggle) begin
          dbModel = ~dbModel;
          lastToggle = t;
        end
        checkOutput("random_btn_db", {31'd0, btn_db}, {31'd0, dbModel});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
